// File: rtl/mem_stage.sv
// Memory stage of the five-stage pipeline: req/ack handshake with a variable-latency
// data memory, watchdog abort of unacknowledged accesses and misaligned-access trap.
module mem_stage #(
  parameter int unsigned WORD     = 32,
  parameter int unsigned REG_SIZE = 5,
  parameter int unsigned TIMEOUT  = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [WORD-1:0]     writeDataM,
  input  logic [WORD-1:0]     ALUResultM,
  input  logic [WORD-1:0]     pcM,
  input  logic [REG_SIZE-1:0] writeRegM,
  input  logic                regWriteM,
  input  logic                memWriteM,
  input  logic                mem2regM,
  input  logic                finishM,
  input  logic                validM,
  output logic                stallM,
  output logic                dmem_req,
  output logic                dmem_we,
  output logic [WORD-1:0]     dmem_addr,
  output logic [WORD-1:0]     dmem_wdata,
  input  logic                dmem_ack,
  input  logic [WORD-1:0]     dmem_rdata,
  output logic [WORD-1:0]     readDataW,
  output logic [WORD-1:0]     ALUResultW,
  output logic [WORD-1:0]     pcW,
  output logic [REG_SIZE-1:0] writeRegW,
  output logic                regWriteW,
  output logic                mem2regW,
  output logic                finishW,
  output logic                validW,
  output logic                busErrW,
  output logic                misalignW
);

  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  state_t      state_q;
  logic [7:0]  cnt_q;

  logic mem_op_s;
  logic aligned_s;
  logic acc_s;
  logic misalign_s;
  logic timeout_s;
  logic done_s;
  logic stall_s;

  logic [WORD-1:0]     readDataW_d, readDataW_q;
  logic [WORD-1:0]     ALUResultW_d, ALUResultW_q;
  logic [WORD-1:0]     pcW_d, pcW_q;
  logic [REG_SIZE-1:0] writeRegW_d, writeRegW_q;
  logic                regWriteW_d, regWriteW_q;
  logic                mem2regW_d, mem2regW_q;
  logic                finishW_d, finishW_q;
  logic                validW_d, validW_q;
  logic                busErrW_d, busErrW_q;
  logic                misalignW_d, misalignW_q;

  // Access decode; reset gates the request so it drops the moment reset asserts.
  always_comb begin
    mem_op_s   = memWriteM | mem2regM;
    aligned_s  = (ALUResultM[1:0] == 2'b00);
    acc_s      = reset & validM & mem_op_s & aligned_s;
    misalign_s = validM & mem_op_s & ~aligned_s;
    timeout_s  = acc_s & ~dmem_ack & (state_q == ST_WAIT) & (cnt_q == TIMEOUT_C);
    done_s     = acc_s & dmem_ack;
    stall_s    = acc_s & ~dmem_ack & ~timeout_s;
  end

  assign stallM     = stall_s;
  assign dmem_req   = acc_s;
  assign dmem_we    = memWriteM;
  assign dmem_addr  = ALUResultM;
  assign dmem_wdata = writeDataM;

  // Handshake FSM with watchdog counter; cnt counts cycles spent waiting for ack.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= 8'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (acc_s && !dmem_ack) begin
            state_q <= ST_WAIT;
            cnt_q   <= 8'd1;
          end else begin
            state_q <= ST_IDLE;
            cnt_q   <= 8'd0;
          end
        end
        ST_WAIT: begin
          if (!acc_s || dmem_ack || timeout_s) begin
            state_q <= ST_IDLE;
            cnt_q   <= 8'd0;
          end else begin
            state_q <= ST_WAIT;
            cnt_q   <= cnt_q + 8'd1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          cnt_q   <= 8'd0;
        end
      endcase
    end
  end

  // Next W-register contents; a stall or an invalid slot loads an all-zero bubble.
  always_comb begin
    readDataW_d  = {WORD{1'b0}};
    ALUResultW_d = {WORD{1'b0}};
    pcW_d        = {WORD{1'b0}};
    writeRegW_d  = {REG_SIZE{1'b0}};
    regWriteW_d  = 1'b0;
    mem2regW_d   = 1'b0;
    finishW_d    = 1'b0;
    validW_d     = 1'b0;
    busErrW_d    = 1'b0;
    misalignW_d  = 1'b0;
    if (validM && !stall_s) begin
      ALUResultW_d = ALUResultM;
      pcW_d        = pcM;
      writeRegW_d  = writeRegM;
      validW_d     = 1'b1;
      finishW_d    = finishM;
      // A store wins over a load when both control bits are set.
      mem2regW_d   = mem2regM & ~memWriteM;
      regWriteW_d  = regWriteM & ~memWriteM;
      if (misalign_s) begin
        misalignW_d = 1'b1;
        regWriteW_d = 1'b0;
      end else if (timeout_s) begin
        busErrW_d   = 1'b1;
        regWriteW_d = 1'b0;
      end else if (done_s && !memWriteM) begin
        readDataW_d = dmem_rdata;
      end else begin
        readDataW_d = {WORD{1'b0}};
      end
    end else begin
      validW_d = 1'b0;
    end
  end

  // W pipeline register, loaded on every edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      readDataW_q  <= {WORD{1'b0}};
      ALUResultW_q <= {WORD{1'b0}};
      pcW_q        <= {WORD{1'b0}};
      writeRegW_q  <= {REG_SIZE{1'b0}};
      regWriteW_q  <= 1'b0;
      mem2regW_q   <= 1'b0;
      finishW_q    <= 1'b0;
      validW_q     <= 1'b0;
      busErrW_q    <= 1'b0;
      misalignW_q  <= 1'b0;
    end else begin
      readDataW_q  <= readDataW_d;
      ALUResultW_q <= ALUResultW_d;
      pcW_q        <= pcW_d;
      writeRegW_q  <= writeRegW_d;
      regWriteW_q  <= regWriteW_d;
      mem2regW_q   <= mem2regW_d;
      finishW_q    <= finishW_d;
      validW_q     <= validW_d;
      busErrW_q    <= busErrW_d;
      misalignW_q  <= misalignW_d;
    end
  end

  assign readDataW  = readDataW_q;
  assign ALUResultW = ALUResultW_q;
  assign pcW        = pcW_q;
  assign writeRegW  = writeRegW_q;
  assign regWriteW  = regWriteW_q;
  assign mem2regW   = mem2regW_q;
  assign finishW    = finishW_q;
  assign validW     = validW_q;
  assign busErrW    = busErrW_q;
  assign misalignW  = misalignW_q;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: instruction-level reference model driving randomized and
// directed traffic, with per-cycle comparison of stall, handshake and W outputs.
module tb_mem_stage;

  localparam int TO = 4;

  typedef struct packed {
    logic [31:0] wd;
    logic [31:0] alu;
    logic [31:0] pc;
    logic [4:0]  wr;
    logic        rw;
    logic        mw;
    logic        m2r;
    logic        fin;
    logic        v;
  } instr_t;

  typedef struct packed {
    logic [31:0] rd;
    logic [31:0] alu;
    logic [31:0] pc;
    logic [4:0]  wr;
    logic        rw;
    logic        m2r;
    logic        fin;
    logic        v;
    logic        berr;
    logic        mis;
  } wout_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] writeDataM, ALUResultM, pcM;
  logic [4:0]  writeRegM;
  logic        regWriteM, memWriteM, mem2regM, finishM, validM;
  logic        stallM, dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic [31:0] readDataW, ALUResultW, pcW;
  logic [4:0]  writeRegW;
  logic        regWriteW, mem2regW, finishW, validW, busErrW, misalignW;

  int    errors = 0;
  int    checks = 0;
  int    fin_seen = 0;
  wout_t w_now;

  mem_stage #(.WORD(32), .REG_SIZE(5), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .writeDataM(writeDataM), .ALUResultM(ALUResultM), .pcM(pcM), .writeRegM(writeRegM),
    .regWriteM(regWriteM), .memWriteM(memWriteM), .mem2regM(mem2regM),
    .finishM(finishM), .validM(validM),
    .stallM(stallM), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .readDataW(readDataW), .ALUResultW(ALUResultW), .pcW(pcW), .writeRegW(writeRegW),
    .regWriteW(regWriteW), .mem2regW(mem2regW), .finishW(finishW), .validW(validW),
    .busErrW(busErrW), .misalignW(misalignW)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic wout_t dut_w();
    return {readDataW, ALUResultW, pcW, writeRegW, regWriteW, mem2regW,
            finishW, validW, busErrW, misalignW};
  endfunction

  task automatic drive(input instr_t in);
    writeDataM = in.wd;
    ALUResultM = in.alu;
    pcM        = in.pc;
    writeRegM  = in.wr;
    regWriteM  = in.rw;
    memWriteM  = in.mw;
    mem2regM   = in.m2r;
    finishM    = in.fin;
    validM     = in.v;
  endtask

  // Per-cycle comparison of the DUT against the model's expectation for that cycle.
  task automatic compare(input logic e_stall, input logic e_req, input instr_t in,
                         input wout_t e_w);
    chk("stallM", stallM, e_stall);
    chk("dmem_req", dmem_req, e_req);
    if (e_req) begin
      chk("dmem_we", dmem_we, in.mw);
      chk("dmem_addr", dmem_addr, in.alu);
      chk("dmem_wdata", dmem_wdata, in.wd);
    end
    chk("W", dut_w(), e_w);
    if (finishW) fin_seen++;
  endtask

  // Model: an instruction accepted with memory ack in cycle n stalls min(n,TO) cycles
  // and then produces one W result; n > TO means the ack never comes (abort).
  task automatic run_instr(input instr_t in, input int n, input logic [31:0] rd,
                           output int stalls);
    logic  mem, mis, acc;
    int    k;
    wout_t res;
    mem = in.v & (in.mw | in.m2r);
    mis = mem & (in.alu[1:0] != 2'b00);
    acc = mem & ~mis;
    k   = acc ? ((n <= TO) ? n : TO) : 0;
    res = '0;
    if (in.v) begin
      res.alu = in.alu;
      res.pc  = in.pc;
      res.wr  = in.wr;
      res.v   = 1'b1;
      res.fin = in.fin;
      res.m2r = in.m2r & ~in.mw;
      res.rw  = in.rw & ~in.mw;
      if (mis) begin
        res.mis = 1'b1;
        res.rw  = 1'b0;
      end else if (acc && n > TO) begin
        res.berr = 1'b1;
        res.rw   = 1'b0;
      end else if (acc && !in.mw) begin
        res.rd = rd;
      end
    end
    stalls = 0;
    for (int c = 0; c <= k; c++) begin
      @(posedge clk); #1;
      drive(in);
      dmem_ack   = acc ? (c == n) : 1'($urandom);
      dmem_rdata = (acc && c == n) ? rd : $urandom;
      @(negedge clk);
      if (stallM) stalls++;
      compare(c < k, acc, in, w_now);
      w_now = (c < k) ? '0 : res;
    end
  endtask

  function automatic instr_t mk(input logic [31:0] alu, input logic [31:0] wd,
                                input logic mw, input logic m2r, input logic fin);
    instr_t r;
    r.wd = wd; r.alu = alu; r.pc = 32'h0000_1000 + alu; r.wr = 5'd7;
    r.rw = 1'b1; r.mw = mw; r.m2r = m2r; r.fin = fin; r.v = 1'b1;
    return r;
  endfunction

  function automatic instr_t rand_instr();
    instr_t r;
    r.wd  = $urandom;
    r.alu = $urandom;
    r.pc  = $urandom;
    r.wr  = 5'($urandom);
    r.rw  = 1'($urandom);
    r.fin = 1'($urandom);
    case ($urandom_range(0, 3))
      0:       begin r.mw = 1'b0; r.m2r = 1'b0; end
      1:       begin r.mw = 1'b0; r.m2r = 1'b1; end
      2:       begin r.mw = 1'b1; r.m2r = 1'b0; end
      default: begin r.mw = 1'b1; r.m2r = 1'b1; end
    endcase
    if ($urandom_range(0, 3) != 0) r.alu[1:0] = 2'b00;
    r.v = ($urandom_range(0, 7) != 0);
    return r;
  endfunction

  instr_t bub;
  int     st;

  initial begin
    bub   = '0;
    w_now = '0;
    reset = 1'b0;
    dmem_ack = 1'b1;
    dmem_rdata = 32'h0;
    drive(mk(32'h0000_0010, 32'h0, 1'b0, 1'b1, 1'b1));
    #12;
    chk("rst_req", dmem_req, 1'b0);
    chk("rst_stall", stallM, 1'b0);
    chk("rst_W", dut_w(), 128'h0);
    validM = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;

    // Zero-wait load.
    run_instr(mk(32'h0000_0010, 32'h0, 1'b0, 1'b1, 1'b0), 0, 32'hDEAD_BEEF, st);
    chk("zw_stalls", st, 0);
    run_instr(bub, 0, 32'h0, st);
    chk("zw_rdata", readDataW, 32'hDEAD_BEEF);
    chk("zw_m2r_valid", {mem2regW, validW}, 2'b11);

    // Three-cycle store.
    run_instr(mk(32'h0000_0020, 32'h1234_5678, 1'b1, 1'b0, 1'b0), 3, 32'h0, st);
    chk("st_stalls", st, 3);
    run_instr(bub, 0, 32'h0, st);
    chk("st_rw_valid", {regWriteW, validW, readDataW}, {2'b01, 32'h0});

    // Watchdog abort.
    run_instr(mk(32'h0000_0030, 32'h0, 1'b0, 1'b1, 1'b0), 100, 32'h0, st);
    chk("to_stalls", st, TO);
    run_instr(bub, 0, 32'h0, st);
    chk("to_flags", {busErrW, regWriteW, validW, readDataW}, {3'b101, 32'h0});

    // Misaligned load.
    run_instr(mk(32'h0000_0013, 32'h0, 1'b0, 1'b1, 1'b0), 0, 32'h0, st);
    chk("mis_stalls", st, 0);
    run_instr(bub, 0, 32'h0, st);
    chk("mis_flags", {misalignW, regWriteW, busErrW}, 3'b100);

    // Reset in the middle of a pending load.
    @(posedge clk); #1;
    drive(mk(32'h0000_0040, 32'h0, 1'b0, 1'b1, 1'b0));
    dmem_ack = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("pre_rst_req", {dmem_req, stallM}, 2'b11);
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_req_stall", {dmem_req, stallM}, 2'b00);
    chk("mid_rst_W", dut_w(), 128'h0);
    @(posedge clk); #1;
    validM = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    w_now = '0;
    run_instr(mk(32'h0000_0ABC, 32'h0, 1'b0, 1'b0, 1'b0), 0, 32'h0, st);
    run_instr(bub, 0, 32'h0, st);
    chk("post_rst_alu", {ALUResultW, validW}, {32'h0000_0ABC, 1'b1});

    // Back-to-back: load, store, finishing ALU op.
    fin_seen = 0;
    run_instr(mk(32'h0000_0100, 32'h0, 1'b0, 1'b1, 1'b0), 1, 32'hA5A5_0001, st);
    run_instr(mk(32'h0000_0104, 32'h0BAD_F00D, 1'b1, 1'b0, 1'b0), 0, 32'h0, st);
    run_instr(mk(32'h0000_0777, 32'h0, 1'b0, 1'b0, 1'b1), 0, 32'h0, st);
    run_instr(bub, 0, 32'h0, st);
    run_instr(bub, 0, 32'h0, st);
    chk("b2b_finish_once", fin_seen, 1);

    // Randomized traffic.
    for (int i = 0; i < 300; i++) begin
      run_instr(rand_instr(), $urandom_range(0, TO + 2), $urandom, st);
    end
    run_instr(bub, 0, 32'h0, st);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory stage of the five-stage pipeline. It sits directly downstream of the execute stage and consumes that stage's registered M-signals. For loads and stores it runs a req/ack handshake with a variable-latency data memory, stalling upstream until the access completes. It then registers the result into the W pipeline register for writeback. A watchdog aborts accesses that are never acknowledged, and misaligned word accesses are trapped.

## Interface
- `TIMEOUT`, 16: max cycles in WAIT before abort (1..255).
- `clk` in 1: single clock, all state on rising edge.
- `reset` in 1: asynchronous, active-low; 0 clears all state immediately.
- `writeDataM` in `WORD`: store data from execute.
- `ALUResultM` in `WORD`: address for load/store, result otherwise.
- `pcM` in `WORD`: instruction PC.
- `writeRegM` in `REG_SIZE`: destination register.
- `regWriteM`, `memWriteM`, `mem2regM`, `finishM`, `validM` in 1 each: control from execute.
- `stallM` out 1: combinational; upstream (execute register and earlier) must hold while high.
- `dmem_req` out 1: access request, combinational.
- `dmem_we` out 1: 1 = store, 0 = load; meaningful only with `dmem_req`.
- `dmem_addr` out `WORD`: equals `ALUResultM`.
- `dmem_wdata` out `WORD`: equals `writeDataM`.
- `dmem_ack` in 1: access complete this cycle.
- `dmem_rdata` in `WORD`: load data, valid only with `dmem_ack`.
- `readDataW`, `ALUResultW`, `pcW` out `WORD`: registered W values.
- `writeRegW` out `REG_SIZE`: registered destination.
- `regWriteW`, `mem2regW`, `finishW`, `validW` out 1 each: registered control.
- `busErrW`, `misalignW` out 1 each: registered fault flags.

## Operation
- Access needed: `acc = validM & (memWriteM | mem2regM) & (ALUResultM[1:0]==0)`.
- If `memWriteM` and `mem2regM` are both set, the access is treated as a store and `mem2regW` is forced to 0.
- Misaligned access (`validM`, mem op, `addr[1:0]!=0`): no request is issued and no stall occurs. The W register gets `misalignW=1`, `regWriteW=0`, `validW=1`.
- FSM states: IDLE, WAIT. The watchdog counter `cnt` is 8 bits.
- IDLE:
  - If `acc`: `dmem_req=1`.
  - If `dmem_ack` arrives in the same cycle, the access completes (zero-wait).
  - Otherwise the FSM goes to WAIT with `cnt=1`.
- WAIT:
  - `dmem_req` stays high; `cnt` increments each cycle.
  - On `dmem_ack`: complete, go to IDLE.
  - When `cnt==TIMEOUT` without ack: abort, go to IDLE. The W register gets `busErrW=1`, `regWriteW=0`, `readDataW=0`, `validW=1`.
  - If ack and timeout occur in the same cycle, the ack wins.
- `stallM = acc & ~dmem_ack & ~timeout_this_cycle`.
- W register loads every edge:
  - `stallM=1`: loads a bubble (all W outputs 0).
  - Completed load: `readDataW = dmem_rdata`.
  - Store: `readDataW = 0`, `regWriteW = regWriteM & ~memWriteM`.
  - Non-memory valid instruction: passes through with no stall; `readDataW = 0`.
  - `validM=0`: bubble.
- `finishW` follows `finishM` only for a completed, non-stalled instruction. The stage never drops or duplicates a finish.
- While `reset=0`: `dmem_req=0`, `stallM=0`, FSM in IDLE, `cnt=0`.

## Timing
- Reset values: every W output is 0 and the FSM is IDLE. Assertion takes effect asynchronously, mid-access included. The memory must discard an in-flight request when `dmem_req` drops.
- Latency:
  - Non-memory instruction: M→W in 1 edge.
  - Ack in cycle n after the request first appears (n=0 is zero-wait): `stallM` is high for cycles 0..n-1, W captures at the edge ending cycle n, and n bubbles are inserted before it.
- Timeout: `stallM` is high for exactly TIMEOUT cycles. The abort result is captured at the edge ending cycle TIMEOUT.
- Handshake:
  - `dmem_addr`, `dmem_we`, `dmem_wdata` stay stable while `dmem_req` is high.
  - `dmem_req` falls in the cycle after ack or abort unless the next instruction also needs an access.
  - Back-to-back accesses cause no idle cycle.
- `dmem_ack` without `dmem_req` is ignored.

## Test plan
- Zero-wait load: addr 0x10, `dmem_ack` held 1, rdata 0xDEADBEEF → no stall; next edge `readDataW=0xDEADBEEF`, `mem2regW=1`, `validW=1`.
- 3-cycle store: addr 0x20, wdata 0x12345678, ack in cycle 3 → `stallM` high 3 cycles with `dmem_we=1` and stable address/data; W shows 3 bubbles, then a store with `regWriteW=0`.
- Timeout: TIMEOUT=4, load with ack never given → `stallM` high 4 cycles; then `busErrW=1`, `regWriteW=0`, `readDataW=0`, FSM back in IDLE.
- Misaligned: load at 0x13 → `dmem_req` never rises, no stall; next edge `misalignW=1`, `regWriteW=0`.
- Reset mid-WAIT: drop `reset` in cycle 2 of a pending load → `dmem_req` and `stallM` go to 0 immediately and all W outputs are 0. After release, an ALU instruction passes through in 1 cycle.
- Back-to-back: load (ack cycle 1), then store (ack cycle 0), then ALU op with `finishM=1` → 1 bubble then three W results in order; `finishW` is high exactly once.
